// File: rtl/alu_pkg.sv
// Shared decode constants, ALU op encodings and issue FSM states.
// No logic: constants and pure decode helpers only.
package alu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ANDI  = 6'd12;

   localparam logic [5:0] FN_SLL = 6'd0;
   localparam logic [5:0] FN_SRL = 6'd2;
   localparam logic [5:0] FN_SRA = 6'd3;
   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;
   localparam logic [5:0] FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37;
   localparam logic [5:0] FN_SLT = 6'd42;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_AND   = 2'd1;
   localparam logic [1:0] ALUOP_RTYPE = 2'd2;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   function automatic logic is_shift(input logic [5:0] fn);
      return fn inside {FN_SLL, FN_SRL, FN_SRA};
   endfunction

   function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
      if (opc == OP_RTYPE)
         return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      return (opc == OP_ADDI) || (opc == OP_ANDI);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32x32 register file, R0 hard-wired to zero, three combinational read ports.
// Write lands on the clock edge; reads in the same cycle see the old value.
module alu_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] dbg_data,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] mem_q [32];
   logic [31:0] mem_d [32];

   always_comb begin
      mem_d = mem_q;
      if (we && (waddr != 5'd0))
         mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rs_data  = (rs_addr  == 5'd0) ? '0 : mem_q[rs_addr];
   assign rt_data  = (rt_addr  == 5'd0) ? '0 : mem_q[rt_addr];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue MIPS ALU sequencer: decode, drive external ALU, write back.
// Accept to done = 2+EXEC_WAIT cycles; instr_ready only in IDLE, one instruction in flight.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int EXEC_WAIT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [31:0]        instr,
   output logic               instr_ready,
   output logic signed [31:0] alu_in1,
   output logic signed [31:0] alu_in2,
   output logic [4:0]         alu_shamt,
   output logic [1:0]         alu_op,
   output logic [5:0]         alu_funct,
   output logic [5:0]         alu_opcode,
   input  logic [31:0]        alu_result,
   output logic               done,
   output logic               exc_ovf,
   output logic               exc_illegal,
   output logic [5:0]         exc_opcode,
   input  logic [4:0]         dbg_raddr,
   output logic [31:0]        dbg_rdata
);

   localparam int CW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

   state_t        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
   logic [4:0]    alu_shamt_q, alu_shamt_d;
   logic [1:0]    alu_op_q, alu_op_d;
   logic [5:0]    alu_funct_q, alu_funct_d, alu_opcode_q, alu_opcode_d;
   logic [31:0]   res_q, res_d;
   logic          ovf_q, ovf_d;
   logic [4:0]    dest_q, dest_d;
   logic          exc_illegal_q, exc_illegal_d;
   logic [5:0]    exc_opcode_q, exc_opcode_d;

   logic [5:0]  opc, fn;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] rs_data, rt_data;
   logic        is_add, is_sub, ovf_now, we;

   assign opc   = instr_q[31:26];
   assign rs    = instr_q[25:21];
   assign rt    = instr_q[20:16];
   assign rd    = instr_q[15:11];
   assign shamt = instr_q[10:6];
   assign fn    = instr_q[5:0];
   assign imm   = instr_q[15:0];

   // Overflow judged on the held operands against the result being sampled.
   assign is_add  = (alu_op_q == ALUOP_ADD) ||
                    ((alu_op_q == ALUOP_RTYPE) && (alu_funct_q == FN_ADD));
   assign is_sub  = (alu_op_q == ALUOP_RTYPE) && (alu_funct_q == FN_SUB);
   assign ovf_now = (is_add && (alu_in1_q[31] == alu_in2_q[31]) && (alu_result[31] != alu_in1_q[31])) ||
                    (is_sub && (alu_in1_q[31] != alu_in2_q[31]) && (alu_result[31] != alu_in1_q[31]));

   alu_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs),
      .rt_addr  (rt),
      .dbg_addr (dbg_raddr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .dbg_data (dbg_rdata),
      .we       (we),
      .waddr    (dest_q),
      .wdata    (res_q)
   );

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      cnt_d         = cnt_q;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_shamt_d   = alu_shamt_q;
      alu_op_d      = alu_op_q;
      alu_funct_d   = alu_funct_q;
      alu_opcode_d  = alu_opcode_q;
      res_d         = res_q;
      ovf_d         = ovf_q;
      dest_d        = dest_q;
      exc_illegal_d = 1'b0;
      exc_opcode_d  = exc_opcode_q;
      unique case (state_q)
         IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (is_legal(opc, fn)) begin
               alu_op_d     = (opc == OP_ADDI) ? ALUOP_ADD :
                              (opc == OP_ANDI) ? ALUOP_AND : ALUOP_RTYPE;
               alu_in1_d    = ((opc == OP_RTYPE) && is_shift(fn)) ? rt_data : rs_data;
               alu_in2_d    = (opc == OP_ADDI) ? {{16{imm[15]}}, imm} :
                              (opc == OP_ANDI) ? {16'd0, imm} :
                              is_shift(fn)     ? 32'd0 : rt_data;
               alu_shamt_d  = shamt;
               alu_funct_d  = fn;
               alu_opcode_d = opc;
               dest_d       = (opc == OP_RTYPE) ? rd : rt;
               cnt_d        = CW'(EXEC_WAIT - 1);
               state_d      = EXEC;
            end else begin
               exc_illegal_d = 1'b1;
               exc_opcode_d  = opc;
               state_d       = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d = alu_result;
               ovf_d = ovf_now;
               if (ovf_now)
                  exc_opcode_d = alu_opcode_q;
               state_d = WB;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         cnt_q         <= '0;
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         alu_shamt_q   <= '0;
         alu_op_q      <= '0;
         alu_funct_q   <= '0;
         alu_opcode_q  <= '0;
         res_q         <= '0;
         ovf_q         <= 1'b0;
         dest_q        <= '0;
         exc_illegal_q <= 1'b0;
         exc_opcode_q  <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         cnt_q         <= cnt_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_shamt_q   <= alu_shamt_d;
         alu_op_q      <= alu_op_d;
         alu_funct_q   <= alu_funct_d;
         alu_opcode_q  <= alu_opcode_d;
         res_q         <= res_d;
         ovf_q         <= ovf_d;
         dest_q        <= dest_d;
         exc_illegal_q <= exc_illegal_d;
         exc_opcode_q  <= exc_opcode_d;
      end
   end

   assign instr_ready = rst_n && (state_q == IDLE);
   assign done        = (state_q == WB);
   assign exc_ovf     = (state_q == WB) && ovf_q;
   assign we          = (state_q == WB) && !ovf_q && (dest_q != 5'd0);
   assign exc_illegal = exc_illegal_q;
   assign exc_opcode  = exc_opcode_q;
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_shamt   = alu_shamt_q;
   assign alu_op      = alu_op_q;
   assign alu_funct   = alu_funct_q;
   assign alu_opcode  = alu_opcode_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboarded random bench for alu_issue_ctrl with a behavioural MIPS model.
// Cycle index of an observation = rising edges so far + 1 (the cycle ending at the next edge).
module tb_alu_issue_ctrl;

   localparam int EW = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               instr_valid;
   logic [31:0]        instr;
   logic               instr_ready;
   logic signed [31:0] alu_in1, alu_in2;
   logic [4:0]         alu_shamt;
   logic [1:0]         alu_op;
   logic [5:0]         alu_funct, alu_opcode;
   logic [31:0]        alu_result;
   logic               done, exc_ovf, exc_illegal;
   logic [5:0]         exc_opcode;
   logic [4:0]         dbg_raddr;
   logic [31:0]        dbg_rdata;

   alu_issue_ctrl #(.EXEC_WAIT(EW)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_shamt(alu_shamt), .alu_op(alu_op), .alu_funct(alu_funct),
      .alu_opcode(alu_opcode), .alu_result(alu_result), .done(done),
      .exc_ovf(exc_ovf), .exc_illegal(exc_illegal), .exc_opcode(exc_opcode),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   // External ALU the controller drives.
   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         2'd0: alu_result = alu_in1 + alu_in2;
         2'd1: alu_result = alu_in1 & alu_in2;
         2'd2: case (alu_funct)
            6'd0:  alu_result = alu_in1 << alu_shamt;
            6'd2:  alu_result = alu_in1 >> alu_shamt;
            6'd3:  alu_result = alu_in1 >>> alu_shamt;
            6'd32: alu_result = alu_in1 + alu_in2;
            6'd34: alu_result = alu_in1 - alu_in2;
            6'd36: alu_result = alu_in1 & alu_in2;
            6'd37: alu_result = alu_in1 | alu_in2;
            6'd42: alu_result = {31'd0, alu_in1 < alu_in2};
            default: alu_result = 32'd0;
         endcase
         default: alu_result = 32'd0;
      endcase
   end

   typedef struct {
      bit          legal;
      bit          ovf;
      logic [5:0]  opc;
      logic [5:0]  fn;
      int          due;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [1:0]  op;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mreg [32];
   int          total = 0;
   int          bad = 0;
   int          ncyc = 0;
   int          last_t = 0;
   int          last_iv = 0;
   bit          have_last = 0;

   always @(posedge clk) ncyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: executes the instruction architecturally and predicts the pulses.
   task automatic model(input logic [31:0] w, input int t, output int iv);
      exp_t        e;
      logic [31:0] a, b, val, sx;
      logic [4:0]  dst;
      longint      s;
      a = mreg[w[25:21]];
      b = mreg[w[20:16]];
      sx = {{16{w[15]}}, w[15:0]};
      e.legal = 1; e.ovf = 0; e.opc = w[31:26]; e.fn = w[5:0];
      e.in1 = a; e.in2 = b; e.op = 2'd2; val = 32'd0; dst = w[15:11];
      if (w[31:26] == 6'd0) begin
         case (w[5:0])
            6'd0:  begin val = b << w[10:6]; e.in1 = b; e.in2 = 0; end
            6'd2:  begin val = b >> w[10:6]; e.in1 = b; e.in2 = 0; end
            6'd3:  begin val = 32'($signed(b) >>> w[10:6]); e.in1 = b; e.in2 = 0; end
            6'd32: begin s = longint'($signed(a)) + longint'($signed(b)); val = a + b; end
            6'd34: begin s = longint'($signed(a)) - longint'($signed(b)); val = a - b; end
            6'd36: val = a & b;
            6'd37: val = a | b;
            6'd42: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.legal = 0;
         endcase
         if (w[5:0] == 6'd32 || w[5:0] == 6'd34)
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (w[31:26] == 6'd8) begin
         s = longint'($signed(a)) + longint'($signed(sx));
         e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         val = a + sx; e.in2 = sx; e.op = 2'd0; dst = w[20:16];
      end else if (w[31:26] == 6'd12) begin
         e.in2 = {16'd0, w[15:0]}; val = a & e.in2; e.op = 2'd1; dst = w[20:16];
      end else begin
         e.legal = 0;
      end
      e.due = e.legal ? t + 2 + EW : t + 2;
      iv = e.legal ? 3 + EW : 2;
      if (e.legal && !e.ovf && dst != 5'd0)
         mreg[dst] = val;
      sb.push_back(e);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (done || exc_illegal || exc_ovf)) begin
         if (sb.size() == 0) begin
            chk("spurious_pulse", {29'd0, done, exc_ovf, exc_illegal}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", 32'(ncyc + 1), 32'(e.due));
            chk("done", {31'd0, done}, {31'd0, e.legal});
            chk("exc_illegal", {31'd0, exc_illegal}, {31'd0, !e.legal});
            chk("exc_ovf", {31'd0, exc_ovf}, {31'd0, e.ovf});
            if (!e.legal || e.ovf)
               chk("exc_opcode", {26'd0, exc_opcode}, {26'd0, e.opc});
            if (e.legal) begin
               chk("alu_in1", alu_in1, e.in1);
               chk("alu_in2", alu_in2, e.in2);
               chk("alu_op", {30'd0, alu_op}, {30'd0, e.op});
               chk("alu_funct", {26'd0, alu_funct}, {26'd0, e.fn});
            end
         end
      end
   end

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rand_instr();
      int k;
      int fns[8];
      fns = '{0, 2, 3, 32, 34, 36, 37, 42};
      k = $urandom_range(0, 19);
      if (k < 9)
         return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 31), fns[$urandom_range(0, 7)]);
      if (k < 11)
         return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 31), $urandom_range(0, 63));
      if (k < 15)
         return itype(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      if (k < 18)
         return itype(12, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      return {6'($urandom_range(0, 63)), 26'($urandom)};
   endfunction

   // Offer w (with garbage while busy), predict on acceptance; called and returns at a falling edge.
   task automatic issue(input logic [31:0] w, input int gap);
      int n;
      int t;
      int iv;
      if (gap > 0) begin
         instr_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 40) begin
         instr = $urandom;
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         chk("accept_timeout", {31'd0, instr_ready}, 32'd1);
         instr_valid = 1'b0;
         return;
      end
      instr = w;
      t = ncyc + 1;
      if (gap == 0 && have_last)
         chk("accept_interval", 32'(t - last_t), 32'(last_iv));
      model(w, t, iv);
      last_t = t; last_iv = iv; have_last = 1;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      instr_valid = 1'b0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
      have_last = 0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; dbg_raddr = 5'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_pulses", {29'd0, done, exc_ovf, exc_illegal}, 32'd0);
      chk("rst_alu_in1", alu_in1, 32'd0);
      chk("rst_exc_opcode", {26'd0, exc_opcode}, 32'd0);

      issue(itype(8, 0, 1, 16'hFFFF), 0);          // R1 = -1
      issue(rtype(0, 1, 1, 1, 2), 0);              // R1 = 0x7FFFFFFF
      issue(itype(8, 0, 3, 1), 0);                 // R3 = 1
      issue(rtype(0, 3, 3, 31, 0), 0);             // R3 = 0x80000000
      issue(rtype(0, 3, 4, 4, 3), 0);              // SRA -> R4 = 0xF8000000
      issue({6'h23, 26'h0421000}, 0);
      issue(rtype(1, 2, 6, 0, 6'h27), 0);
      issue({6'h3F, 26'd0}, 0);
      issue(rtype(1, 1, 2, 0, 32), 0);             // ADD overflow, R2 untouched
      issue(itype(12, 1, 0, 16'hFFFF), 0);         // ANDI rt=0
      drain();
      dbg_raddr = 5'd0; #1;
      chk("dbg_r0", dbg_rdata, 32'd0);
      dbg_raddr = 5'd4; #1;
      chk("dbg_r4_sra", dbg_rdata, 32'hF800_0000);
      dbg_raddr = 5'd2; #1;
      chk("dbg_r2_ovf_nowrite", dbg_rdata, 32'd0);
      dbg_raddr = 5'd0;

      for (int i = 0; i < 150; i++)
         issue(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      drain();

      // Reset while an ADD to R5 is in EXEC.
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      instr = rtype(1, 3, 5, 0, 32);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_alu_in1", alu_in1, 32'd0);
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
      dbg_raddr = 5'd5; #1;
      chk("rst_mid_r5", dbg_rdata, 32'd0);
      dbg_raddr = 5'd0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 40; i++)
         issue(rand_instr(), ($urandom_range(0, 3) == 0) ? 1 : 0);
      drain();

      for (int i = 0; i < 32; i++) begin
         dbg_raddr = 5'(i);
         #1;
         chk($sformatf("reg_r%0d", i), dbg_rdata, mreg[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter EXEC_WAIT, default 1, meaning: cycles (>=1) the ALU inputs are held before alu_result is sampled.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr  in  32  MIPS instruction: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
REQ-006 instr_ready  out  1  block can accept an instruction.
REQ-007 alu_in1, alu_in2  out  32 each  signed ALU operands.
REQ-008 alu_shamt  out  5; alu_op  out  2; alu_funct  out  6; alu_opcode  out  6  ALU control fields.
REQ-009 alu_result  in  32  combinational ALU result.
REQ-010 done  out  1  one-cycle pulse: instruction retired.
REQ-011 exc_ovf  out  1; exc_illegal  out  1  one-cycle exception pulses.
REQ-012 exc_opcode  out  6  opcode of most recent faulting instruction.
REQ-013 dbg_raddr  in  5; dbg_rdata  out  32  combinational register-file read port.

Function
REQ-014 FSM states IDLE, DECODE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-015 IDLE->DECODE on instr_valid&instr_ready, capturing instr; otherwise stay IDLE.
REQ-016 DECODE SHALL read rs/rt and classify: opcode 0 with funct in {0,2,3,32,34,36,37,42}, opcode 8 (ADDI), opcode 12 (ANDI) legal; all else illegal.
REQ-017 Illegal: DECODE->IDLE, no ALU drive, no write, exc_illegal=1 for the next cycle, exc_opcode<=opcode.
REQ-018 Legal: DECODE->EXEC; EXEC lasts exactly EXEC_WAIT cycles, then WB for one cycle, then IDLE.
REQ-019 Latency: accept edge T -> done high in cycle T+2+EXEC_WAIT; throughput one instruction per 3+EXEC_WAIT cycles.
REQ-020 alu_op SHALL be 0 for ADDI, 1 for ANDI, 2 for R-type; alu_funct=funct, alu_opcode=opcode, alu_shamt=shamt.
REQ-021 Operands: R-type non-shift in1=R[rs], in2=R[rt]; shifts in1=R[rt], in2=0; ADDI in2=sign-extended imm; ANDI in2=zero-extended imm; I-type in1=R[rs].
REQ-022 ALU outputs SHALL be registered, updated on DECODE->EXEC, held stable through WB and IDLE until the next legal DECODE.
REQ-023 alu_result SHALL be sampled at the last EXEC edge; WB uses only the sampled value.
REQ-024 Overflow computed internally: ADD/ADDI when sign(in1)==sign(in2) and sign(result)!=sign(in1); SUB when sign(in1)!=sign(in2) and sign(result)!=sign(in1); other ops never overflow.
REQ-025 WB destination rd for R-type, rt for I-type; write SHALL be suppressed when destination is 0 or overflow detected.
REQ-026 On overflow, exc_ovf=1 in the WB cycle together with done, exc_opcode<=opcode.
REQ-027 Register 0 SHALL read 0 on every port regardless of writes.
REQ-028 dbg_rdata during WB to the same register SHALL return the pre-write value (write lands at end of WB).
REQ-029 instr_valid changes outside IDLE SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, all 32 registers to 0, all outputs to 0 except instr_ready=1 once released.
REQ-031 Reset mid-instruction SHALL abort with no register write and no done/exception pulse.

Structure
REQ-032 Shared package alu_pkg SHALL hold opcode/funct constants, alu_op encodings (ALUOP_ADD=0, ALUOP_AND=1, ALUOP_RTYPE=2) and the FSM state enum.
REQ-033 Register file SHALL be sub-module alu_regfile: 32x32, three combinational read ports (rs, rt, dbg), one synchronous write port, async active-low clear.

Verification
REQ-034 Reset, ADDI rt=1 rs=0 imm=0xFFFF -> alu_op=0, alu_in2=0xFFFFFFFF, result -1 written to R1, done at T+3 (EXEC_WAIT=1).
REQ-035 R1=0x7FFFFFFF, ADD rd=2 rs=1 rt=1 -> exc_ovf=1 with done, exc_opcode=0, R2 unchanged at 0.
REQ-036 R3=0x80000000, SRA rd=4 rt=3 shamt=4 -> alu_in1=0x80000000, alu_funct=3, R4=ALU result (0xF8000000 from a correct ALU).
REQ-037 opcode 0x23 and R-type funct 0x27 -> exc_illegal pulse, exc_opcode=0x23 then 0, no writes, instr_ready back next cycle.
REQ-038 ANDI rt=0 -> no write, dbg read of R0 = 0; instr_valid held high continuously -> one acceptance per 4 cycles.
REQ-039 rst_n asserted during EXEC of ADD rd=5 -> no done, R5=0, instr_ready=1 after release.
